mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/lsu_load_align.sv | 39 +++
 rtl/mem_stage_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: funct3 access encodings, LSU FSM
// states, default timeout and the store-lane helpers used by mem_stage_lsu.
package riscv_pkg;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // An access is legal when funct3 is a known size and the address is
    // naturally aligned for that size.
    function automatic logic lsu_legal(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~lo[0];
            F3_W:        ok = (lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << lo;
            F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick
    // the bytes that land in memory.
    function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B, F3_BU: d = {4{wd[7:0]}};
            F3_H, F3_HU: d = {2{wd[15:0]}};
            default:     d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: picks the addressed byte/half from a read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            F3_W:    data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: a three-state IDLE/REQ/DONE handshake with the
// data memory, stalling the pipeline while a request is outstanding.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_M,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] ALU_result_M,
    input  logic [31:0] WriteData_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadData_M,
    output logic        lsu_busy,
    output logic        done_M,
    output logic        err_M
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        access;
    logic        legal;
    logic        start;
    logic [31:0] load_data;

    assign access = valid_M & (MemRead_M | MemWrite_M);
    assign legal  = lsu_legal(funct3_M, ALU_result_M[1:0]);
    assign start  = access & legal;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    state_d = LSU_REQ;
                    req_d   = 1'b1;
                    we_d    = MemWrite_M & ~MemRead_M;
                    be_d    = lsu_be(funct3_M, ALU_result_M[1:0]);
                    addr_d  = {ALU_result_M[31:2], 2'b00};
                    wdata_d = lsu_wdata(funct3_M, WriteData_M);
                    f3_d    = funct3_M;
                    lo_d    = ALU_result_M[1:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LSU_REQ: begin
                if (dmem_ready) begin
                    state_d = LSU_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    rdata_d = dmem_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LSU_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = LSU_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                be_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    lsu_load_align u_load_align (
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .rdata   (rdata_q),
        .data    (load_data)
    );

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    // Misaligned/illegal accesses are rejected in IDLE without stalling; the
    // error pulse rides on the same cycle as the offending instruction.
    assign lsu_busy   = (state_q == LSU_REQ) | ((state_q == LSU_IDLE) & start);
    assign done_M     = (state_q == LSU_DONE);
    assign err_M      = ((state_q == LSU_DONE) & err_q) |
                        ((state_q == LSU_IDLE) & access & ~legal);
    assign ReadData_M = ((state_q == LSU_DONE) & ~err_q) ? load_data : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expected
// completions; a negedge monitor pops and compares on done_M/err_M.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_M, MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALU_result_M, WriteData_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadData_M;
    logic        lsu_busy, done_M, err_M;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        done;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_M      (valid_M),
        .MemRead_M    (MemRead_M),
        .MemWrite_M   (MemWrite_M),
        .funct3_M     (funct3_M),
        .ALU_result_M (ALU_result_M),
        .WriteData_M  (WriteData_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .ReadData_M   (ReadData_M),
        .lsu_busy     (lsu_busy),
        .done_M       (done_M),
        .err_M        (err_M)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done_M === 1'b1 || err_M === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done_M, err_M}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_done"}, {31'd0, done_M}, {31'd0, e.done});
                chk({e.name, "_err"},  {31'd0, err_M},  {31'd0, e.err});
                chk({e.name, "_rdata"}, ReadData_M, e.rd);
            end
        end
    end

    task automatic idle_inputs();
        valid_M      = 1'b0;
        MemRead_M    = 1'b0;
        MemWrite_M   = 1'b0;
        funct3_M     = 3'b000;
        ALU_result_M = '0;
        WriteData_M  = '0;
        dmem_ready   = 1'b0;
        dmem_rdata   = '0;
    endtask

    // latency: REQ cycle number on which dmem_ready is high (0 = never).
    task automatic run_access(
        input string       name,
        input logic        rd_en,
        input logic        wr_en,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [31:0] mem_rd,
        input int          latency,
        input logic        exp_illegal,
        input logic        exp_err,
        input logic [31:0] exp_rd,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic        exp_we,
        input int          exp_busy
    );
        int   busy = 0;
        int   reqc = 0;
        logic seen_done = 1'b0;
        @(posedge clk); #1;
        valid_M      = 1'b1;
        MemRead_M    = rd_en;
        MemWrite_M   = wr_en;
        funct3_M     = f3;
        ALU_result_M = addr;
        WriteData_M  = wd;
        dmem_rdata   = mem_rd;
        dmem_ready   = 1'b0;
        exp_q.push_back('{name: name, done: ~exp_illegal, err: exp_err, rd: exp_rd});
        if (exp_illegal) begin
            @(negedge clk);
            chk({name, "_busy"}, {31'd0, lsu_busy}, 32'd0);
            chk({name, "_req"},  {31'd0, dmem_req}, 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk({name, "_req_after"}, {31'd0, dmem_req}, 32'd0);
            return;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (lsu_busy) busy++;
            if (dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk({name, "_addr"},  dmem_addr, exp_addr);
                    chk({name, "_be"},    {28'd0, dmem_be}, {28'd0, exp_be});
                    chk({name, "_we"},    {31'd0, dmem_we}, {31'd0, exp_we});
                    if (exp_we) chk({name, "_wdata"}, dmem_wdata, exp_wdata);
                end
            end
            if (done_M) begin
                seen_done = 1'b1;
                chk({name, "_busy_in_done"}, {31'd0, lsu_busy}, 32'd0);
                break;
            end
            @(posedge clk); #1;
            dmem_ready = (latency != 0) && (reqc + 1 == latency);
        end
        if (!seen_done) chk({name, "_no_done"}, 32'd0, 32'd1);
        chk({name, "_busy_cycles"}, busy, exp_busy);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",  {31'd0, dmem_req}, 32'd0);
        chk("rst_we",   {31'd0, dmem_we},  32'd0);
        chk("rst_be",   {28'd0, dmem_be},  32'd0);
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_done", {31'd0, done_M},   32'd0);
        chk("rst_err",  {31'd0, err_M},    32'd0);
        chk("rst_rd",   ReadData_M,        32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          name    rd    wr    f3      addr          wd            mem_rd        lat ill  err  exp_rd        exp_addr      be       wdata         we   busy
        run_access("lw",    1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 2);
        run_access("lb",    1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 1, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 2);
        run_access("lbu",   1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 2, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 3);
        run_access("lh_hi", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1'b0, 1'b0, 32'hFFFF_8001, 32'h0000_0100, 4'b1100, 32'h0,        1'b0, 2);
        run_access("lhu",   1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1'b0, 1'b0, 32'h0000_8001, 32'h0000_0100, 4'b1100, 32'h0,        1'b0, 2);
        run_access("lh_lo", 1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h8001_7FFF, 3, 1'b0, 1'b0, 32'h0000_7FFF, 32'h0000_0100, 4'b0011, 32'h0,        1'b0, 4);
        run_access("sh",    1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 1'b0, 1'b0, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b1, 2);
        run_access("sb",    1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 1'b0, 1'b0, 32'h0,        32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 1'b1, 2);
        run_access("sw",    1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 1'b0, 32'h0,        32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 1'b1, 2);
        run_access("ld_pri",1'b1, 1'b1, 3'b010, 32'h0000_010C, 32'h1111_1111, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0000_010C, 4'b1111, 32'h0,        1'b0, 2);
        run_access("lw_mis",1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 0);
        run_access("lh_mis",1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        1, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 0);
        run_access("bad_f3",1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 1'b1, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 0);
        run_access("tmo",   1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h5555_5555, 0, 1'b0, 1'b1, 32'h0,        32'h0000_0400, 4'b1111, 32'h0,        1'b0, 17);

        // Stray ready strobes while idle must not start or complete anything.
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stray_busy", {31'd0, lsu_busy}, 32'd0);
        chk("stray_req",  {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Reset during the third REQ cycle aborts the access without done_M.
        @(posedge clk); #1;
        valid_M      = 1'b1;
        MemRead_M    = 1'b1;
        funct3_M     = 3'b010;
        ALU_result_M = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq_req_before", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rstreq_req",  {31'd0, dmem_req}, 32'd0);
        chk("rstreq_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rstreq_be",   {28'd0, dmem_be},  32'd0);
        chk("rstreq_rd",   ReadData_M,        32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rstreq_still_idle", {31'd0, dmem_req}, 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
